// File: rtl/bp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bp_pkg : shared branch-history table widths and counter update     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bp_pkg;

    localparam int IDX_W = 13;
    localparam int CNT_W = 2;

    localparam logic [CNT_W-1:0] CNT_MIN = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating 2-bit counter step; never wraps at either end.
    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                    input logic             taken);
        if (taken) begin
            return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
        return (cnt == CNT_MIN) ? cnt : cnt - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_outcome_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bp_outcome_fifo : synchronous FIFO, push accepted on full with pop   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bp_outcome_fifo #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [DATA_W-1:0]      wdata_i,
    output logic [DATA_W-1:0]      rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              w_push;
    logic              w_pop;

    assign full_o  = (count_q == c_DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_update_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bp_update_unit : buffered read-modify-write of branch-history table  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bp_update_unit #(
    parameter int IDX_W      = bp_pkg::IDX_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = bp_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_taken,
    output logic [IDX_W-1:0] tbl_raddr,
    input  logic [CNT_W-1:0] tbl_rdata,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_waddr,
    output logic [CNT_W-1:0] tbl_wdata,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_MIN = '0;

    logic [IDX_W:0]              w_fifo_wdata;
    logic [IDX_W:0]              w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_pop;
    logic                        w_drop;
    logic                        w_unused_pc;

    logic                        s1_valid_q;
    logic [IDX_W-1:0]            s1_idx_q;
    logic                        s1_taken_q;
    logic                        byp_valid_q;
    logic [IDX_W-1:0]            byp_idx_q;
    logic [CNT_W-1:0]            byp_cnt_q;
    logic                        we_q;
    logic [IDX_W-1:0]            waddr_q;
    logic [CNT_W-1:0]            wdata_q;
    logic [7:0]                  drop_cnt_q;
    logic [CNT_W-1:0]            w_base;
    logic [CNT_W-1:0]            cnt_d;

    assign w_unused_pc  = ^{res_pc[31:IDX_W+2], res_pc[1:0]};
    assign w_fifo_wdata = {res_pc[IDX_W+1:2], res_taken};
    assign w_pop        = ~w_empty;
    assign w_drop       = res_valid & w_full & ~w_pop;

    bp_outcome_fifo #(
        .DATA_W (IDX_W + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (res_valid),
        .pop_i   (w_pop),
        .wdata_i (w_fifo_wdata),
        .rdata_o (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign tbl_raddr = w_empty ? '0 : w_head[IDX_W:1];

    // The previous write is not yet in the table when this entry's read was issued.
    assign w_base = (byp_valid_q && (byp_idx_q == s1_idx_q)) ? byp_cnt_q : tbl_rdata;

    always_comb begin
        cnt_d = w_base;
        if (s1_taken_q) begin
            if (w_base != c_CNT_MAX) cnt_d = w_base + 1'b1;
        end else begin
            if (w_base != c_CNT_MIN) cnt_d = w_base - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_taken_q  <= 1'b0;
            byp_valid_q <= 1'b0;
            byp_idx_q   <= '0;
            byp_cnt_q   <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            drop_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= w_pop;
            s1_idx_q    <= w_head[IDX_W:1];
            s1_taken_q  <= w_head[0];
            we_q        <= s1_valid_q;
            byp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                waddr_q   <= s1_idx_q;
                wdata_q   <= cnt_d;
                byp_idx_q <= s1_idx_q;
                byp_cnt_q <= cnt_d;
            end
            if (w_drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign tbl_we    = we_q;
    assign tbl_waddr = waddr_q;
    assign tbl_wdata = wdata_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (w_count != '0) | s1_valid_q | we_q;

endmodule
`default_nettype wire
